// File: rtl/uart_prog_loader_pkg.sv
// Shared frame constants and state encodings for the UART program loader.
package uart_prog_loader_pkg;

    localparam logic [7:0] HDR_IMEM = 8'hA0;
    localparam logic [7:0] HDR_DMEM = 8'hA1;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT0,
        ST_CNT1,
        ST_DATA,
        ST_FINISH
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 byte receiver: 2-FF sync, falling-edge start detect, mid-bit sampling.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CPB = 179
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    localparam int HALF = CPB / 2;

    logic [2:0]  sync;
    rx_state_t   st, st_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sh, sh_n, byte_n;
    logic        valid_n;
    logic        rx_s, fall;

    assign rx_s = sync[1];
    // Edge, not level: a line still low after a framing error is not a start.
    assign fall = sync[2] & ~sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 3'b111;
            st      <= RX_IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            byte_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            sync    <= {sync[1:0], rx};
            st      <= st_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            byte_o  <= byte_n;
            valid_o <= valid_n;
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        byte_n  = byte_o;
        valid_n = 1'b0;
        unique case (st)
            RX_IDLE: begin
                if (fall) begin
                    st_n  = RX_START;
                    cnt_n = '0;
                end
            end
            RX_START: begin
                if (cnt == 16'(HALF - 1)) begin
                    cnt_n = '0;
                    idx_n = '0;
                    st_n  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt == 16'(CPB - 1)) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    if (idx == 3'd7) st_n = RX_STOP;
                    else idx_n = idx + 3'd1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt == 16'(CPB - 1)) begin
                    st_n = RX_IDLE;
                    if (rx_s) begin
                        valid_n = 1'b1;
                        byte_n  = sh;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: st_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: framed image in, word writes out on upg_*, ACK/NAK back.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_HZ    = 23_000_000,
    parameter int BAUD      = 128_000,
    parameter int MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        tx
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int TMO = 1024 * CPB;

    logic [7:0]  rb;
    logic        bv;
    ld_state_t   st, st_n;
    logic        tgt, tgt_n;
    logic [15:0] cnt, cnt_n;
    logic [13:0] widx, widx_n;
    logic [1:0]  bidx, bidx_n;
    logic [23:0] word, word_n;
    logic        wen_n, done_n;
    logic [14:0] adr_n;
    logic [31:0] dat_n;
    logic [31:0] tmo, tmo_n;
    logic        tmo_hit;
    logic        tx_req;
    logic [7:0]  tx_byte;
    logic [9:0]  tx_sh;
    logic [3:0]  tx_bits;
    logic [15:0] tx_cnt;

    uart_rx_byte #(.CPB(CPB)) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .byte_o (rb),
        .valid_o(bv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            tgt        <= 1'b0;
            cnt        <= '0;
            widx       <= '0;
            bidx       <= '0;
            word       <= '0;
            tmo        <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
        end else begin
            st         <= st_n;
            tgt        <= tgt_n;
            cnt        <= cnt_n;
            widx       <= widx_n;
            bidx       <= bidx_n;
            word       <= word_n;
            tmo        <= tmo_n;
            upg_wen_o  <= wen_n;
            upg_adr_o  <= adr_n;
            upg_dat_o  <= dat_n;
            upg_done_o <= done_n;
        end
    end

    always_comb begin
        st_n    = st;
        tgt_n   = tgt;
        cnt_n   = cnt;
        widx_n  = widx;
        bidx_n  = bidx;
        word_n  = word;
        wen_n   = 1'b0;
        adr_n   = upg_adr_o;
        dat_n   = upg_dat_o;
        done_n  = upg_done_o;
        tx_req  = 1'b0;
        tx_byte = ACK;
        tmo_hit = (tmo == 32'(TMO - 1));
        unique case (st)
            ST_IDLE: begin
                if (bv) begin
                    if (rb == HDR_IMEM || rb == HDR_DMEM) begin
                        tgt_n = (rb == HDR_DMEM);
                        st_n  = ST_CNT0;
                    end else begin
                        tx_req  = 1'b1;
                        tx_byte = NAK;
                    end
                end
            end
            ST_CNT0: begin
                if (bv) begin
                    cnt_n  = {8'h00, rb};
                    done_n = 1'b0;
                    st_n   = ST_CNT1;
                end else if (tmo_hit) begin
                    tx_req  = 1'b1;
                    tx_byte = NAK;
                    st_n    = ST_IDLE;
                end
            end
            ST_CNT1: begin
                if (bv) begin
                    cnt_n  = {rb, cnt[7:0]};
                    widx_n = '0;
                    bidx_n = '0;
                    if (cnt_n == 16'd0 || cnt_n > 16'(MAX_WORDS)) begin
                        tx_req  = 1'b1;
                        tx_byte = NAK;
                        st_n    = ST_IDLE;
                    end else begin
                        st_n = ST_DATA;
                    end
                end else if (tmo_hit) begin
                    tx_req  = 1'b1;
                    tx_byte = NAK;
                    st_n    = ST_IDLE;
                end
            end
            ST_DATA: begin
                // A byte arriving on the expiry cycle is still accepted.
                if (bv) begin
                    word_n = {rb, word[23:8]};
                    bidx_n = bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        wen_n  = 1'b1;
                        adr_n  = {tgt, widx};
                        dat_n  = {rb, word};
                        widx_n = widx + 14'd1;
                        if ({2'b00, widx} + 16'd1 == cnt) st_n = ST_FINISH;
                    end
                end else if (tmo_hit) begin
                    tx_req  = 1'b1;
                    tx_byte = NAK;
                    st_n    = ST_IDLE;
                end
            end
            ST_FINISH: begin
                done_n = 1'b1;
                tx_req = 1'b1;
                st_n   = ST_IDLE;
            end
            default: st_n = ST_IDLE;
        endcase
        tmo_n = '0;
        if (!bv && st_n inside {ST_CNT0, ST_CNT1, ST_DATA}) tmo_n = tmo + 32'd1;
    end

    // Responses requested while a byte is still shifting out are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh   <= '1;
            tx_bits <= '0;
            tx_cnt  <= '0;
        end else if (tx_bits == 4'd0) begin
            if (tx_req) begin
                tx_sh   <= {1'b1, tx_byte, 1'b0};
                tx_bits <= 4'd10;
                tx_cnt  <= '0;
            end
        end else if (tx_cnt == 16'(CPB - 1)) begin
            tx_cnt  <= '0;
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_bits <= tx_bits - 4'd1;
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    assign tx = tx_sh[0];

endmodule
